ahbl_bus_n: RTL and testbench

AHBL_BUS_N -- requirements
Module: ahbl_bus_n

---
 rtl/ahbl_bus_pkg.sv | 11 +
 rtl/ahbl_bus_dflt.sv | 64 ++++++
 rtl/ahbl_bus_n.sv | 81 ++++++++
 tb/tb_ahbl_bus_n.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_bus_pkg.sv
// ahbl_bus_pkg: shared AHB-Lite encodings, default-slave state type and read-data default
package ahbl_bus_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;
   localparam logic [31:0] DEF_RDATA_DFLT = 32'hDEADBEEF;
   typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} dflt_state_e;
endpackage

// File: rtl/ahbl_bus_dflt.sv
// ahbl_bus_dflt: default-slave ERROR FSM plus optional wait-state timeout (AHBL_BUS_TIMEOUT_EN)
module ahbl_bus_dflt
   import ahbl_bus_pkg::*;
#(
   parameter int TO_CYCLES = 255
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic hready_i,
   input  logic unmapped_i,
   input  logic stall_i,
   output logic ready_o,
   output logic resp_o,
   output logic to_hit_o
`ifdef AHBL_BUS_TIMEOUT_EN
   ,
   output logic timeout_o
`endif
);
   dflt_state_e state_q, state_d;

   // state register
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) state_q <= ST_IDLE;
      else state_q <= state_d;

   // a timeout or an accepted unmapped transfer starts the two-cycle ERROR; ERR1 always advances
   always_comb
      state_d = (to_hit_o || (hready_i && unmapped_i && state_q != ST_ERR1)) ? ST_ERR1 :
                (state_q == ST_ERR1) ? ST_ERR2 : ST_IDLE;

   // ERR1 stalls the master, both error states flag ERROR
   always_comb begin
      ready_o = state_q != ST_ERR1;
      resp_o  = (state_q == ST_IDLE) ? HRESP_OKAY : HRESP_ERROR;
   end

`ifdef AHBL_BUS_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q;

   assign to_hit_o  = stall_i && (cnt_q == CW'(TO_CYCLES - 1));
   assign timeout_o = timeout_q;

   // count stalled cycles of the current owner; any completed cycle or a timeout clears it
   always_comb
      cnt_d = (hready_i || to_hit_o) ? '0 : stall_i ? cnt_q + 1'b1 : cnt_q;

   // counter and one-cycle timeout pulse registers
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= to_hit_o;
      end
`else
   logic unused_to;
   assign to_hit_o  = 1'b0;
   assign unused_to = stall_i ^ (TO_CYCLES != 0);
`endif
endmodule

// File: rtl/ahbl_bus_n.sv
// ahbl_bus_n: AHB-Lite page decoder and response mux with default slave (optional AHBL_BUS_TIMEOUT_EN)
module ahbl_bus_n
   import ahbl_bus_pkg::*;
#(
   parameter int             NS        = 6,
   parameter int             DW        = 32,
   parameter int             PW        = 8,
   parameter logic [NS*PW-1:0] PAGE_MAP = {8'h4A, 8'h49, 8'h48, 8'h40, 8'h20, 8'h00},
   parameter logic [DW-1:0]  DEF_RDATA = DW'(DEF_RDATA_DFLT),
   parameter int             TO_CYCLES = 255
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   output logic             HREADY,
   output logic             HRESP,
   output logic [DW-1:0]    HRDATA,
   output logic [NS-1:0]    HSEL,
   input  logic [NS-1:0]    HREADY_S,
   input  logic [NS-1:0]    HRESP_S,
   input  logic [NS*DW-1:0] HRDATA_S
`ifdef AHBL_BUS_TIMEOUT_EN
   ,
   output logic             TIMEOUT
`endif
);
   logic [PW-1:0] page;
   logic [NS-1:0] asel_q, asel_d;
   logic          unmapped, stall, to_hit, dflt_ready, dflt_resp;
   logic          unused_haddr;

   assign page         = HADDR[31 -: PW];
   assign unmapped     = HTRANS[1] & ~|HSEL;
   assign stall        = |asel_q & ~HREADY;
   assign unused_haddr = ^{HADDR[31-PW:0], HTRANS[0]};

   // page decode; scanning downward lets the lowest matching index win on duplicates
   always_comb begin
      HSEL = '0;
      for (int i = NS - 1; i >= 0; i--)
         if (page == PAGE_MAP[i*PW +: PW]) HSEL = NS'(1) << i;
   end

   // data-phase owner: reloaded on every completed cycle, dropped when a stalled slave times out
   always_comb
      asel_d = to_hit ? '0 : HREADY ? (HTRANS[1] ? HSEL : '0) : asel_q;

   // data-phase owner register
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) asel_q <= '0;
      else asel_q <= asel_d;

   // response mux: owning slave if any, otherwise the default slave
   always_comb begin
      HREADY = dflt_ready;
      HRESP  = dflt_resp;
      HRDATA = DEF_RDATA;
      for (int i = 0; i < NS; i++)
         if (asel_q[i]) begin
            HREADY = HREADY_S[i];
            HRESP  = HRESP_S[i];
            HRDATA = HRDATA_S[i*DW +: DW];
         end
   end

   ahbl_bus_dflt #(.TO_CYCLES(TO_CYCLES)) u_dflt (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .hready_i   (HREADY),
      .unmapped_i (unmapped),
      .stall_i    (stall),
      .ready_o    (dflt_ready),
      .resp_o     (dflt_resp),
      .to_hit_o   (to_hit)
`ifdef AHBL_BUS_TIMEOUT_EN
      ,
      .timeout_o  (TIMEOUT)
`endif
   );
endmodule

// File: tb/tb_ahbl_bus_n.sv
// tb_ahbl_bus_n: directed and randomized checks of ahbl_bus_n against a transaction-level model
module tb_ahbl_bus_n;
   localparam int NS = 6;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam logic [31:0] DEF = 32'hDEADBEEF;
   localparam logic [7:0] PAGES [NS] = '{8'h00, 8'h20, 8'h40, 8'h48, 8'h49, 8'h4A};

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic [31:0]      haddr;
   logic [1:0]       htrans;
   logic             hready, hresp, timeout;
   logic [DW-1:0]    hrdata;
   logic [NS-1:0]    hsel, hready_s, hresp_s;
   logic [NS*DW-1:0] hrdata_s;

   int   n_chk = 0;
   int   n_fail = 0;
   int   owner = -1;
   int   err = 0;
   int   cnt = 0;
   logic mto = 1'b0;

   always #5 clk = ~clk;

   ahbl_bus_n #(.TO_CYCLES(TO)) dut (
      .HCLK(clk), .HRESETn(rstn), .HADDR(haddr), .HTRANS(htrans),
      .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .HSEL(hsel),
      .HREADY_S(hready_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s)
`ifdef AHBL_BUS_TIMEOUT_EN
      , .TIMEOUT(timeout)
`endif
   );
`ifndef AHBL_BUS_TIMEOUT_EN
   assign timeout = 1'b0;
`endif

   // reference model: owner = slave index of the data phase (-1 none), err = error cycle number (0 none)
   function automatic int m_match();
      for (int i = 0; i < NS; i++) if (haddr[31:24] == PAGES[i]) return i;
      return -1;
   endfunction
   function automatic logic [NS-1:0] m_sel();
      int m = m_match();
      return (m < 0) ? '0 : NS'(1) << m;
   endfunction
   function automatic logic m_ready();
      return (owner >= 0) ? hready_s[owner] : (err != 1);
   endfunction
   function automatic logic m_resp();
      return (owner >= 0) ? hresp_s[owner] : (err != 0);
   endfunction
   function automatic logic [DW-1:0] m_rdata();
      return (owner >= 0) ? hrdata_s[owner*DW +: DW] : DEF;
   endfunction

   task automatic model_clk();
      logic r;
      int   m;
      r = m_ready();
      m = m_match();
      mto = 1'b0;
      if (!rstn) begin
         owner = -1; err = 0; cnt = 0;
         return;
      end
`ifdef AHBL_BUS_TIMEOUT_EN
      if (owner >= 0 && !r) begin
         cnt++;
         if (cnt == TO) begin
            owner = -1; err = 1; cnt = 0; mto = 1'b1;
            return;
         end
      end
`endif
      if (r) begin
         cnt = 0;
         owner = (htrans[1] && m >= 0) ? m : -1;
         err = (htrans[1] && m < 0) ? 1 : 0;
      end else if (err == 1) err = 2;
   endtask

   task automatic tick();
      @(posedge clk);
      model_clk();
      #1;
   endtask

   task automatic idle_bus();
      haddr = 32'h0;
      htrans = 2'b00;
      hready_s = '1;
      hresp_s = '0;
      for (int i = 0; i < NS; i++) hrdata_s[i*DW +: DW] = $urandom;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle_bus();
      hready_s = '0;
      #2;
      n_chk++;
      if ({hready, hresp, hrdata, timeout} !== {1'b1, 1'b0, DEF, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b resp=%b rdata=%h to=%b, expected 1 0 %h 0", hready, hresp, hrdata, timeout, DEF);
      end
      repeat (2) tick();
      rstn = 1'b1;
      idle_bus();
      @(negedge clk);
      n_chk++;
      if ({hready, hresp, hrdata} !== {1'b1, 1'b0, DEF}) begin
         n_fail++;
         $display("FAIL reset_release: rdy=%b resp=%b rdata=%h, expected 1 0 %h", hready, hresp, hrdata, DEF);
      end
      tick();
   endtask

   task automatic test_mapped_wait();
      logic [31:0] d1;
      idle_bus();
      haddr = 32'h2000_0010;
      htrans = 2'b10;
      @(negedge clk);
      n_chk++;
      if (hsel !== 6'b000010 || hready !== 1'b1) begin
         n_fail++;
         $display("FAIL mapped_sel: hsel=%b rdy=%b, expected 000010 1", hsel, hready);
      end
      tick();
      haddr = 32'h0;
      htrans = 2'b00;
      d1 = $urandom;
      hrdata_s[DW +: DW] = d1;
      for (int c = 0; c < 3; c++) begin
         hready_s[1] = (c == 2);
         @(negedge clk);
         n_chk++;
         if ({hready, hrdata} !== {logic'(c == 2), d1}) begin
            n_fail++;
            $display("FAIL mapped_wait c%0d: rdy=%b rdata=%h, expected %b %h", c, hready, hrdata, c == 2, d1);
         end
         tick();
      end
   endtask

   task automatic test_unmapped();
      logic [1:0] exp [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
      idle_bus();
      for (int c = 0; c < 4; c++) begin
         haddr = (c == 0) ? 32'h5000_0000 : 32'h0;
         htrans = (c == 0) ? 2'b10 : 2'b00;
         @(negedge clk);
         n_chk++;
         if ({hready, hresp, hrdata} !== {exp[c], DEF} || (c == 0 && hsel !== '0)) begin
            n_fail++;
            $display("FAIL unmapped c%0d: rdy=%b resp=%b rdata=%h hsel=%b, expected %b %h", c, hready, hresp, hrdata, hsel, exp[c], DEF);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [6] = '{32'h5000_0000, 32'h5100_0000, 32'h5100_0000, 32'h0, 32'h0, 32'h0};
      logic [1:0]  t [6] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
      logic [1:0]  exp [6] = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b11, 2'b10};
      idle_bus();
      for (int c = 0; c < 6; c++) begin
         haddr = a[c];
         htrans = t[c];
         @(negedge clk);
         n_chk++;
         if ({hready, hresp, hrdata} !== {exp[c], DEF}) begin
            n_fail++;
            $display("FAIL back_to_back c%0d: rdy=%b resp=%b rdata=%h, expected %b %h", c, hready, hresp, hrdata, exp[c], DEF);
         end
         tick();
      end
   endtask

   task automatic test_idle_unmapped();
      logic [1:0] t [3] = '{2'b00, 2'b01, 2'b00};
      idle_bus();
      for (int c = 0; c < 3; c++) begin
         haddr = 32'h5000_0000;
         htrans = t[c];
         @(negedge clk);
         n_chk++;
         if ({hready, hresp, hrdata} !== {1'b1, 1'b0, DEF}) begin
            n_fail++;
            $display("FAIL idle_unmapped c%0d: rdy=%b resp=%b rdata=%h, expected 1 0 %h", c, hready, hresp, hrdata, DEF);
         end
         tick();
      end
   endtask

`ifdef AHBL_BUS_TIMEOUT_EN
   task automatic test_timeout();
      logic [2:0] exp [8] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b110, 3'b100};
      idle_bus();
      for (int c = 0; c < 8; c++) begin
         haddr = (c == 0) ? 32'h4000_0000 : 32'h0;
         htrans = (c == 0) ? 2'b10 : 2'b00;
         hready_s[2] = (c == 0);
         @(negedge clk);
         n_chk++;
         if ({hready, hresp, timeout} !== exp[c] || (c == 0 && hsel !== 6'b000100) || (c >= 5 && hrdata !== DEF)) begin
            n_fail++;
            $display("FAIL timeout c%0d: rdy=%b resp=%b to=%b hsel=%b rdata=%h, expected %b", c, hready, hresp, timeout, hsel, hrdata, exp[c]);
         end
         tick();
      end
      idle_bus();
   endtask
`endif

   task automatic test_reset_mid();
      idle_bus();
      haddr = 32'h5000_0000;
      htrans = 2'b10;
      tick();
      htrans = 2'b00;
      #1;
      n_chk++;
      if (hready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_err1: rdy=%b, expected 0", hready);
      end
      rstn = 1'b0;
      #1;
      n_chk++;
      if ({hready, hresp, hrdata} !== {1'b1, 1'b0, DEF}) begin
         n_fail++;
         $display("FAIL reset_mid_err1_rst: rdy=%b resp=%b rdata=%h, expected 1 0 %h", hready, hresp, hrdata, DEF);
      end
      tick();
      rstn = 1'b1;
      haddr = 32'h4900_0000;
      htrans = 2'b10;
      tick();
      htrans = 2'b00;
      hready_s[4] = 1'b0;
      #1;
      n_chk++;
      if (hready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_wait: rdy=%b, expected 0", hready);
      end
      rstn = 1'b0;
      #1;
      n_chk++;
      if ({hready, hresp, hrdata} !== {1'b1, 1'b0, DEF}) begin
         n_fail++;
         $display("FAIL reset_mid_wait_rst: rdy=%b resp=%b rdata=%h, expected 1 0 %h", hready, hresp, hrdata, DEF);
      end
      tick();
      rstn = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({hready, hresp, hrdata} !== {1'b1, 1'b0, DEF}) begin
         n_fail++;
         $display("FAIL reset_mid_release: rdy=%b resp=%b rdata=%h, expected 1 0 %h", hready, hresp, hrdata, DEF);
      end
      tick();
      idle_bus();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         haddr = {($urandom_range(0, 3) != 0) ? PAGES[$urandom_range(0, NS - 1)] : 8'($urandom), 24'($urandom)};
         htrans = 2'($urandom_range(0, 3));
         for (int i = 0; i < NS; i++) begin
            hready_s[i] = ($urandom_range(0, 3) != 0);
            hresp_s[i] = ($urandom_range(0, 7) == 0);
            hrdata_s[i*DW +: DW] = $urandom;
         end
         @(negedge clk);
         n_chk++;
         if ({hsel, hready, hresp, hrdata, timeout} !== {m_sel(), m_ready(), m_resp(), m_rdata(), mto}) begin
            n_fail++;
            $display("FAIL random c%0d: hsel=%b rdy=%b resp=%b rdata=%h to=%b, expected %b %b %b %h %b", c,
                     hsel, hready, hresp, hrdata, timeout, m_sel(), m_ready(), m_resp(), m_rdata(), mto);
         end
         tick();
      end
      idle_bus();
   endtask

   initial begin
      test_reset();
      test_mapped_wait();
      test_unmapped();
      test_back_to_back();
      test_idle_unmapped();
`ifdef AHBL_BUS_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
